// File: rtl/fp_add_seq.sv
// fp_add_seq: sequential floating-point adder (capture, align, add, normalize), truncating, no rounding.
// Define FP_ADD_SEQ_FAST_ALIGN_EN for single-cycle barrel-shift alignment instead of serial shifting.
module fp_add_seq #(
   parameter int WIDTH = 48,
   parameter int EXP_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_s,
   input  logic             b_s,
   input  logic [EXP_W-1:0] a_e,
   input  logic [EXP_W-1:0] b_e,
   input  logic [WIDTH-1:0] a_m,
   input  logic [WIDTH-1:0] b_m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             z_s,
   output logic [EXP_W-1:0] z_e,
   output logic [WIDTH-1:0] z_m,
   output logic             ovf,
   output logic             busy
);
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t           state_reg, state_next;
   logic             l_s_reg, l_s_next;
   logic             sub_reg, sub_next;
   logic [EXP_W-1:0] exp_reg, exp_next;
   logic [EXP_W-1:0] d_reg, d_next;
   logic [WIDTH-1:0] l_m_reg, l_m_next;
   logic [WIDTH-1:0] s_m_reg, s_m_next;
   logic [WIDTH:0]   sum_reg, sum_next;
   logic             z_s_reg, z_s_next;
   logic [EXP_W-1:0] z_e_reg, z_e_next;
   logic [WIDTH-1:0] z_m_reg, z_m_next;
   logic             ovf_reg, ovf_next;

   logic a_larger;
   logic d_big;

   // Larger-magnitude operand becomes L; ties go to a so equal operands subtract to zero.
   assign a_larger = (a_e > b_e) || ((a_e == b_e) && (a_m >= b_m));
   assign d_big    = 32'(d_reg) >= 32'(WIDTH);

   assign z_s = z_s_reg;
   assign z_e = z_e_reg;
   assign z_m = z_m_reg;
   assign ovf = ovf_reg;

   always_comb begin
      state_next = state_reg;
      l_s_next   = l_s_reg;
      sub_next   = sub_reg;
      exp_next   = exp_reg;
      d_next     = d_reg;
      l_m_next   = l_m_reg;
      s_m_next   = s_m_reg;
      sum_next   = sum_reg;
      z_s_next   = z_s_reg;
      z_e_next   = z_e_reg;
      z_m_next   = z_m_reg;
      ovf_next   = ovf_reg;
      in_ready   = (state_reg == IDLE);
      out_valid  = (state_reg == DONE);
      busy       = (state_reg != IDLE);

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               l_s_next   = a_larger ? a_s : b_s;
               sub_next   = a_s ^ b_s;
               exp_next   = a_larger ? a_e : b_e;
               l_m_next   = a_larger ? a_m : b_m;
               s_m_next   = a_larger ? b_m : a_m;
               d_next     = a_larger ? (a_e - b_e) : (b_e - a_e);
               ovf_next   = 1'b0;
               state_next = ALIGN;
            end
         end
         ALIGN: begin
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
            s_m_next   = d_big ? '0 : (s_m_reg >> d_reg);
            d_next     = '0;
            state_next = ADD;
`else
            if (d_big) begin
               s_m_next   = '0;
               d_next     = '0;
               state_next = ADD;
            end else if (d_reg != '0) begin
               s_m_next = {1'b0, s_m_reg[WIDTH-1:1]};
               d_next   = d_reg - 1'b1;
            end else begin
               state_next = ADD;
            end
`endif
         end
         ADD: begin
            sum_next   = sub_reg ? ({1'b0, l_m_reg} - {1'b0, s_m_reg})
                                 : ({1'b0, l_m_reg} + {1'b0, s_m_reg});
            state_next = NORM;
         end
         NORM: begin
            if (sum_reg[WIDTH]) begin
               if (exp_reg == '1) begin
                  z_s_next   = l_s_reg;
                  z_e_next   = '1;
                  z_m_next   = '0;
                  ovf_next   = 1'b1;
                  state_next = DONE;
               end else begin
                  sum_next = {1'b0, sum_reg[WIDTH:1]};
                  exp_next = exp_reg + 1'b1;
               end
            end else if (sum_reg == '0) begin
               z_s_next   = 1'b0;
               z_e_next   = '0;
               z_m_next   = '0;
               state_next = DONE;
            end else if (!sum_reg[WIDTH-1] && (exp_reg != '0)) begin
               sum_next = {sum_reg[WIDTH-1:0], 1'b0};
               exp_next = exp_reg - 1'b1;
            end else begin
               // Also the exponent-floor exit: mantissa may be left unnormalized at z_e=0.
               z_s_next   = l_s_reg;
               z_e_next   = exp_reg;
               z_m_next   = sum_reg[WIDTH-1:0];
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg <= IDLE;
         l_s_reg   <= 1'b0;
         sub_reg   <= 1'b0;
         exp_reg   <= '0;
         d_reg     <= '0;
         l_m_reg   <= '0;
         s_m_reg   <= '0;
         sum_reg   <= '0;
         z_s_reg   <= 1'b0;
         z_e_reg   <= '0;
         z_m_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         l_s_reg   <= l_s_next;
         sub_reg   <= sub_next;
         exp_reg   <= exp_next;
         d_reg     <= d_next;
         l_m_reg   <= l_m_next;
         s_m_reg   <= s_m_next;
         sum_reg   <= sum_next;
         z_s_reg   <= z_s_next;
         z_e_reg   <= z_e_next;
         z_m_reg   <= z_m_next;
         ovf_reg   <= ovf_next;
      end
   end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed vectors with hand-computed results and latencies for fp_add_seq (WIDTH=8, EXP_W=8).
module tb_fp_add_seq;
   localparam int WIDTH = 8;
   localparam int EXP_W = 8;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             a_s = 1'b0, b_s = 1'b0;
   logic [EXP_W-1:0] a_e = '0, b_e = '0;
   logic [WIDTH-1:0] a_m = '0, b_m = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             z_s;
   logic [EXP_W-1:0] z_e;
   logic [WIDTH-1:0] z_m;
   logic             ovf;
   logic             busy;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   fp_add_seq #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_s(a_s), .b_s(b_s), .a_e(a_e), .b_e(b_e), .a_m(a_m), .b_m(b_m),
      .out_valid(out_valid), .out_ready(out_ready),
      .z_s(z_s), .z_e(z_e), .z_m(z_m), .ovf(ovf), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic run_op(input string tag,
                         input logic as, input logic [7:0] ae, input logic [7:0] am,
                         input logic bs, input logic [7:0] be, input logic [7:0] bm,
                         input logic es, input logic [7:0] ee, input logic [7:0] em, input logic eovf,
                         input int lat_serial, input int lat_fast, input int hold);
      int lat;
      int exp_lat;
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
      exp_lat = lat_fast;
`else
      exp_lat = lat_serial;
`endif
      @(negedge CLK);
      check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      a_s = as; a_e = ae; a_m = am;
      b_s = bs; b_e = be; b_m = bm;
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge CLK); #1;
         lat++;
      end
      check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "/z_s"}, 32'(z_s), 32'(es));
      check({tag, "/z_e"}, 32'(z_e), 32'(ee));
      check({tag, "/z_m"}, 32'(z_m), 32'(em));
      check({tag, "/ovf"}, 32'(ovf), 32'(eovf));
      for (int h = 0; h < hold; h++) begin
         @(posedge CLK); #1;
         check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "/hold_z"}, {15'd0, z_s, z_e, z_m}, {15'd0, es, ee, em});
         check({tag, "/hold_ovf"}, 32'(ovf), 32'(eovf));
      end
      $display("op %s: z=%0b/%02h/%02h ovf=%0b latency=%0d", tag, z_s, z_e, z_m, ovf, lat);
      @(negedge CLK);
      out_ready = 1'b1;
      @(posedge CLK); #1;
      out_ready = 1'b0;
      check({tag, "/idle_valid"}, 32'(out_valid), 32'd0);
      check({tag, "/idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int pulses;
      int norm_wait;
      // Reset with in_valid asserted: must be ignored.
      RST = 1'b0;
      a_e = 8'h7F; a_m = 8'h80; b_e = 8'h7F; b_m = 8'h80;
      in_valid = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst/in_ready", 32'(in_ready), 32'd1);
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/busy", 32'(busy), 32'd0);
      check("rst/z", {15'd0, z_s, z_e, z_m}, 32'd0);
      check("rst/ovf", 32'(ovf), 32'd0);
      @(negedge CLK);
      in_valid = 1'b0;
      RST = 1'b1;
      @(posedge CLK); #1;
      check("rst/busy_after", 32'(busy), 32'd0);

      //      tag         as    ae     am     bs    be     bm     es    ee     em     ovf  ser fst hold
      run_op("equal_exp", 1'b0, 8'h7F, 8'h80, 1'b0, 8'h7F, 8'h80, 1'b0, 8'h80, 8'h80, 1'b0, 4, 4, 0);
      run_op("align3",    1'b0, 8'h82, 8'h80, 1'b0, 8'h7F, 8'h80, 1'b0, 8'h82, 8'h90, 1'b0, 6, 3, 0);
      run_op("sub_lsh2",  1'b0, 8'h7F, 8'h80, 1'b1, 8'h7E, 8'hC0, 1'b0, 8'h7D, 8'h80, 1'b0, 6, 5, 0);
      run_op("cancel",    1'b0, 8'h7F, 8'hC0, 1'b1, 8'h7F, 8'hC0, 1'b0, 8'h00, 8'h00, 1'b0, 3, 3, 0);
      run_op("d_big",     1'b0, 8'h8C, 8'h80, 1'b0, 8'h7F, 8'h80, 1'b0, 8'h8C, 8'h80, 1'b0, 3, 3, 0);
      run_op("overflow",  1'b0, 8'hFF, 8'h80, 1'b0, 8'hFF, 8'h80, 1'b0, 8'hFF, 8'h00, 1'b1, 3, 3, 3);
      run_op("b_larger",  1'b1, 8'h7F, 8'h80, 1'b0, 8'h80, 8'h80, 1'b0, 8'h7F, 8'h80, 1'b0, 5, 4, 0);
      run_op("exp_floor", 1'b0, 8'h01, 8'h20, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'h40, 1'b0, 4, 4, 0);
      run_op("neg_res",   1'b1, 8'h80, 8'hC0, 1'b0, 8'h80, 8'h40, 1'b1, 8'h80, 8'h80, 1'b0, 3, 3, 0);

      // Reset during the second NORM cycle of the two-left-shift case.
`ifdef FP_ADD_SEQ_FAST_ALIGN_EN
      norm_wait = 3;
`else
      norm_wait = 4;
`endif
      @(negedge CLK);
      a_s = 1'b0; a_e = 8'h7F; a_m = 8'h80;
      b_s = 1'b1; b_e = 8'h7E; b_m = 8'hC0;
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (norm_wait) @(posedge CLK);
      #1;
      check("midrst/busy_before", 32'(busy), 32'd1);
      check("midrst/valid_before", 32'(out_valid), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK); #1;
      check("midrst/in_ready", 32'(in_ready), 32'd1);
      check("midrst/busy", 32'(busy), 32'd0);
      check("midrst/z", {15'd0, z_s, z_e, z_m}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      pulses = 0;
      repeat (10) begin
         @(posedge CLK); #1;
         if (out_valid) pulses++;
      end
      check("midrst/no_valid", 32'(pulses), 32'd0);
      $display("op midrst: reset in NORM, out_valid pulses=%0d", pulses);

      run_op("recover",   1'b0, 8'h7F, 8'h80, 1'b0, 8'h7F, 8'h80, 1'b0, 8'h80, 8'h80, 1'b0, 4, 4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_add_seq.md
FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 Parameter WIDTH, default 48, mantissa width including explicit leading 1.
REQ-002 Parameter EXP_W, default 8, unsigned biased exponent width.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST  input  1  reset: synchronous, active-low.
REQ-005 in_valid  input  1  operand pair valid; in_ready  output  1  block accepts operands.
REQ-006 a_s, b_s  input  1  operand signs; a_e, b_e  input  EXP_W  exponents; a_m, b_m  input  WIDTH  mantissas.
REQ-007 out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-008 z_s  output  1, z_e  output  EXP_W, z_m  output  WIDTH  result; ovf  output  1  exponent overflow; busy  output  1  state != IDLE.

Function
REQ-009 FSM states IDLE, ALIGN, ADD, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-010 IDLE: on in_valid&in_ready, register operands, go ALIGN.
REQ-011 Capture ordering: L=a if a_e>b_e or (a_e==b_e and a_m>=b_m), else L=b; S = other; d = L_e - S_e.
REQ-012 ALIGN (default): per cycle, if d>0 shift S mantissa right 1 (zero fill), d-=1; when d==0 go ADD; d>=WIDTH at capture clears S mantissa and d in the first ALIGN cycle.
REQ-013 ADD: one cycle; sum (WIDTH+1 bits) = L_m+S_m if L_s==S_s, else L_m-S_m; go NORM.
REQ-014 NORM, one action per cycle: sum[WIDTH]=1 -> shift right 1, exp+1; sum==0 -> z=0 (s=0,e=0,m=0), go DONE; sum[WIDTH-1]=0 and exp>0 -> shift left 1, exp-1; otherwise go DONE.
REQ-015 Exponent reaching 0 in NORM stops shifting; unnormalized mantissa output with z_e=0.
REQ-016 Carry with exp all-ones: z_e=all-ones, z_m=0, ovf=1, go DONE.
REQ-017 Result sign = L sign; exact cancellation gives z_s=0.
REQ-018 No rounding; shifted-out bits truncated.
REQ-019 DONE: z_*, ovf stable while out_valid&!out_ready; on out_ready go IDLE; new operands not accepted in the same cycle.
REQ-020 ovf cleared on every new capture.

Reset
REQ-021 RST=0 at a clock edge: state IDLE, in_ready=1, out_valid=0, busy=0, z_s=0, z_e=0, z_m=0, ovf=0, internal registers 0.
REQ-022 Reset mid-operation (any state) abandons the operation; no out_valid pulse follows.
REQ-023 in_valid ignored in the cycle RST=0.

Configuration
REQ-024 Macro FP_ADD_SEQ_FAST_ALIGN_EN defined: ALIGN performs full shift by d (zero if d>=WIDTH) in exactly 1 cycle via barrel shifter.
REQ-025 Undefined: ALIGN uses REQ-012 serial shifting (d+1 cycles, 1 cycle if d>=WIDTH); results identical either way, only latency differs.

Verification (bench WIDTH=8, EXP_W=8; values hex)
REQ-026 a=+(e7F,m80), b=+(e7F,m80) -> z=+(e80,m80), ovf=0; out_valid 4 cycles after handshake (ALIGN1, ADD1, NORM carry 1, NORM final 1).
REQ-027 a=+(e82,m80), b=+(e7F,m80) -> S shifted to m10, z=+(e82,m90); serial ALIGN 4 cycles, FAST 1 cycle.
REQ-028 a=+(e7F,m80), b=-(e7E,mC0) -> diff m20, two left shifts -> z=+(e7D,m80).
REQ-029 a=+(e7F,mC0), b=-(e7F,mC0) -> z=+(e00,m00); a=+(e8C,m80), b=+(e7F,m80) (d>=WIDTH) -> z=+(e8C,m80).
REQ-030 a=+(eFF,m80), b=+(eFF,m80) -> ovf=1, z_e=FF, z_m=00; out_ready low 3 cycles -> outputs held, then IDLE.
REQ-031 RST=0 during NORM -> next cycle IDLE, in_ready=1, out_valid never asserted for that operation.
